// File: rtl/tb_latency_mem_pkg.sv
// Shared types and limits for the latency-configurable testbench memory.
package tb_latency_mem_pkg;

  localparam int unsigned MaxReadLatency = 8;
  localparam int unsigned StatsWidth     = 32;
  localparam int unsigned DataWidth      = 64;

  typedef struct packed {
    logic                 valid;
    logic                 err;
    logic [DataWidth-1:0] rdata;
  } resp_t;

endpackage

// File: rtl/tb_latency_mem_pipe.sv
// Response delay line: Depth registered stages with synchronous active-high clear.
module tb_latency_mem_pipe
  import tb_latency_mem_pkg::*;
#(
  parameter int unsigned Depth  = 1,
  parameter type         elem_t = resp_t
) (
  input  logic  clk_i,
  input  logic  rst_i,
  input  elem_t in_i,
  output elem_t out_o
);

  elem_t r_stage [Depth];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        r_stage[i] <= '0;
      end
    end else begin
      r_stage[0] <= in_i;
      for (int unsigned i = 1; i < Depth; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign out_o = r_stage[Depth-1];

endmodule

// File: rtl/tb_latency_mem.sv
// Testbench memory with configurable read latency, periodic grant stalls and byte-strobe writes.
// Optional handshake statistics are enabled with TB_LATENCY_MEM_STATS_EN.
module tb_latency_mem #(
  parameter int unsigned NumWords       = 256,
  parameter int unsigned DataWidth      = 64,
  parameter int unsigned AddrWidth      = 12,
  parameter int unsigned ReadLatency    = 1,
  parameter int unsigned GntStallPeriod = 0
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   req_i,
  output logic                   gnt_o,
  input  logic [AddrWidth-1:0]   addr_i,
  input  logic                   we_i,
  input  logic [DataWidth-1:0]   wdata_i,
  input  logic [DataWidth/8-1:0] strb_i,
  output logic                   rvalid_o,
  output logic [DataWidth-1:0]   rdata_o,
  output logic                   err_o,
  output logic [31:0]            rd_cnt_o,
  output logic [31:0]            wr_cnt_o
);
  import tb_latency_mem_pkg::*;

  localparam int unsigned NumBytes = DataWidth / 8;
  localparam int unsigned OffW     = $clog2(NumBytes);
  localparam int unsigned IdxW     = AddrWidth - OffW;
  localparam int unsigned MemIdxW  = (NumWords > 1) ? $clog2(NumWords) : 1;
  localparam int unsigned GcntW    = (GntStallPeriod > 0) ? $clog2(GntStallPeriod + 1) : 1;

  typedef struct packed {
    logic                 valid;
    logic                 err;
    logic [DataWidth-1:0] rdata;
  } mem_resp_t;

  if (ReadLatency < 1 || ReadLatency > MaxReadLatency) begin : g_bad_latency
    $error("ReadLatency must be within 1..%0d", MaxReadLatency);
  end
  if (DataWidth % 8 != 0) begin : g_bad_width
    $error("DataWidth must be a multiple of 8");
  end
  if (NumWords > (64'd1 << IdxW)) begin : g_bad_depth
    $error("NumWords exceeds the addressable word range");
  end

  logic [DataWidth-1:0] r_mem [NumWords];
  logic [GcntW-1:0]     r_gcnt;
  logic [IdxW-1:0]      w_idx;
  logic [MemIdxW-1:0]   w_mem_idx;
  logic                 w_in_range;
  logic                 w_stall;
  logic                 w_hs;
  mem_resp_t            w_resp;
  mem_resp_t            w_out;

  assign w_idx      = addr_i[AddrWidth-1:OffW];
  assign w_mem_idx  = w_idx[MemIdxW-1:0];
  assign w_in_range = (64'(w_idx) < 64'(NumWords));

  assign w_stall = (GntStallPeriod != 0) && (r_gcnt == GcntW'(GntStallPeriod));
  assign gnt_o   = req_i && !w_stall;
  assign w_hs    = req_i && gnt_o && !rst_i;

  // A stall is consumed only by a cycle that actually carries a request.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_gcnt <= '0;
    end else if (req_i && w_stall) begin
      r_gcnt <= '0;
    end else if (w_hs) begin
      r_gcnt <= r_gcnt + 1'b1;
    end
  end

  // Array is deliberately not reset so contents survive a harness reset.
  always_ff @(posedge clk_i) begin
    if (w_hs && we_i && w_in_range) begin
      for (int unsigned b = 0; b < NumBytes; b++) begin
        if (strb_i[b]) begin
          r_mem[w_mem_idx][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  always_comb begin
    w_resp = '0;
    if (w_hs) begin
      w_resp.valid = 1'b1;
      w_resp.err   = !w_in_range;
      if (!we_i && w_in_range) begin
        w_resp.rdata = r_mem[w_mem_idx];
      end
    end
  end

  tb_latency_mem_pipe #(
    .Depth  (ReadLatency),
    .elem_t (mem_resp_t)
  ) u_pipe (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .in_i  (w_resp),
    .out_o (w_out)
  );

  assign rvalid_o = w_out.valid;
  assign err_o    = w_out.err;
  assign rdata_o  = w_out.rdata;

`ifdef TB_LATENCY_MEM_STATS_EN
  logic [StatsWidth-1:0] r_rd_cnt;
  logic [StatsWidth-1:0] r_wr_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rd_cnt <= '0;
      r_wr_cnt <= '0;
    end else if (w_hs) begin
      if (we_i) begin
        r_wr_cnt <= r_wr_cnt + 1'b1;
      end else begin
        r_rd_cnt <= r_rd_cnt + 1'b1;
      end
    end
  end

  assign rd_cnt_o = r_rd_cnt;
  assign wr_cnt_o = r_wr_cnt;
`else
  assign rd_cnt_o = '0;
  assign wr_cnt_o = '0;
`endif

endmodule

// File: tb/tb_tb_latency_mem.sv
// Directed self-checking bench: instance A (latency 3, no stall), instance B (latency 4, stall 2).
module tb_tb_latency_mem;

`ifdef TB_LATENCY_MEM_STATS_EN
  localparam int unsigned ExpRd = 5;
  localparam int unsigned ExpWr = 3;
`else
  localparam int unsigned ExpRd = 0;
  localparam int unsigned ExpWr = 0;
`endif

  localparam logic [63:0] D1 = 64'h1122_3344_5566_7788;
  localparam logic [63:0] D2 = 64'hA5A5_0F0F_1234_CAFE;

  typedef struct {
    int          cyc;
    logic [63:0] rdata;
    logic        err;
  } rsp_t;

  logic clk = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  logic        a_rst = 1'b1, a_req = 1'b0, a_gnt, a_we = 1'b0, a_rvalid, a_err;
  logic [11:0] a_addr = '0;
  logic [63:0] a_wdata = '0, a_rdata;
  logic [7:0]  a_strb = '0;
  logic [31:0] a_rd_cnt, a_wr_cnt;

  logic        b_rst = 1'b1, b_req = 1'b0, b_gnt, b_we = 1'b0, b_rvalid, b_err;
  logic [11:0] b_addr = '0;
  logic [63:0] b_wdata = '0, b_rdata;
  logic [7:0]  b_strb = '0;
  logic [31:0] b_rd_cnt, b_wr_cnt;

  int   a_hs_q[$], b_hs_q[$];
  rsp_t a_rsp_q[$], b_rsp_q[$];

  tb_latency_mem #(
    .NumWords(256), .DataWidth(64), .AddrWidth(12), .ReadLatency(3), .GntStallPeriod(0)
  ) u_dut_a (
    .clk_i(clk), .rst_i(a_rst), .req_i(a_req), .gnt_o(a_gnt), .addr_i(a_addr), .we_i(a_we),
    .wdata_i(a_wdata), .strb_i(a_strb), .rvalid_o(a_rvalid), .rdata_o(a_rdata), .err_o(a_err),
    .rd_cnt_o(a_rd_cnt), .wr_cnt_o(a_wr_cnt)
  );

  tb_latency_mem #(
    .NumWords(256), .DataWidth(64), .AddrWidth(12), .ReadLatency(4), .GntStallPeriod(2)
  ) u_dut_b (
    .clk_i(clk), .rst_i(b_rst), .req_i(b_req), .gnt_o(b_gnt), .addr_i(b_addr), .we_i(b_we),
    .wdata_i(b_wdata), .strb_i(b_strb), .rvalid_o(b_rvalid), .rdata_o(b_rdata), .err_o(b_err),
    .rd_cnt_o(b_rd_cnt), .wr_cnt_o(b_wr_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Log handshakes and responses mid-cycle, tagged with the cycle index.
  always @(negedge clk) begin
    if (a_req && a_gnt && !a_rst) a_hs_q.push_back(cyc);
    if (a_rvalid) a_rsp_q.push_back('{cyc: cyc, rdata: a_rdata, err: a_err});
    if (b_req && b_gnt && !b_rst) b_hs_q.push_back(cyc);
    if (b_rvalid) b_rsp_q.push_back('{cyc: cyc, rdata: b_rdata, err: b_err});
  end

  task automatic a_drive(input logic req, input logic we, input logic [11:0] addr,
                         input logic [63:0] wd, input logic [7:0] strb);
    a_req = req; a_we = we; a_addr = addr; a_wdata = wd; a_strb = strb;
    @(posedge clk); #1;
  endtask

  task automatic a_idle(input int n);
    repeat (n) a_drive(1'b0, 1'b0, 12'h0, 64'h0, 8'h0);
  endtask

  task automatic b_idle(input int n);
    b_req = 1'b0; b_we = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset;
    repeat (2) begin @(posedge clk); #1; end
    a_rst = 1'b0; b_rst = 1'b0;
    n_checks++;
    if (a_rvalid !== 1'b0 || a_err !== 1'b0 || b_rvalid !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_valid: got a_rvalid=%b a_err=%b b_rvalid=%b want 0 0 0",
               a_rvalid, a_err, b_rvalid);
    end
    n_checks++;
    if (a_rdata !== 64'h0) begin
      n_errors++; $display("FAIL reset_rdata: got %h want 0", a_rdata);
    end
    n_checks++;
    if (a_rd_cnt !== 32'h0 || a_wr_cnt !== 32'h0) begin
      n_errors++; $display("FAIL reset_cnt: got rd=%0d wr=%0d want 0 0", a_rd_cnt, a_wr_cnt);
    end
    a_req = 1'b1; b_req = 1'b1; #1;
    n_checks++;
    if (a_gnt !== 1'b1 || b_gnt !== 1'b1) begin
      n_errors++; $display("FAIL reset_gnt: got a=%b b=%b want 1 1", a_gnt, b_gnt);
    end
    a_req = 1'b0; b_req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_write_read;
    logic [63:0] exp_d [2];
    exp_d = '{64'h0, D1};
    a_hs_q.delete(); a_rsp_q.delete();
    a_drive(1'b1, 1'b1, 12'h010, D1, 8'hFF);
    a_drive(1'b1, 1'b0, 12'h010, 64'h0, 8'h0);
    a_idle(6);
    n_checks++;
    if (a_hs_q.size() != 2 || a_rsp_q.size() != 2) begin
      n_errors++;
      $display("FAIL wr_rd_count: got hs=%0d rsp=%0d want 2 2", a_hs_q.size(), a_rsp_q.size());
    end
    for (int i = 0; i < 2; i++) begin
      if (i < a_hs_q.size() && i < a_rsp_q.size()) begin
        n_checks++;
        if (a_rsp_q[i].cyc - a_hs_q[i] != 3) begin
          n_errors++;
          $display("FAIL wr_rd_latency[%0d]: got %0d want 3", i, a_rsp_q[i].cyc - a_hs_q[i]);
        end
        n_checks++;
        if (a_rsp_q[i].rdata !== exp_d[i] || a_rsp_q[i].err !== 1'b0) begin
          n_errors++;
          $display("FAIL wr_rd_data[%0d]: got %h err=%b want %h err=0",
                   i, a_rsp_q[i].rdata, a_rsp_q[i].err, exp_d[i]);
        end
      end
    end
  endtask

  task automatic test_strobes;
    a_hs_q.delete(); a_rsp_q.delete();
    a_drive(1'b1, 1'b1, 12'h020, 64'h0, 8'hFF);
    a_drive(1'b1, 1'b1, 12'h020, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F);
    a_drive(1'b1, 1'b0, 12'h020, 64'h0, 8'h0);
    a_idle(6);
    n_checks++;
    if (a_rsp_q.size() != 3) begin
      n_errors++; $display("FAIL strb_count: got %0d want 3", a_rsp_q.size());
    end else if (a_rsp_q[2].rdata !== 64'h0000_0000_FFFF_FFFF) begin
      n_errors++;
      $display("FAIL strb_data: got %h want 00000000ffffffff", a_rsp_q[2].rdata);
    end
  endtask

  task automatic test_out_of_range;
    logic [63:0] exp_d [4];
    logic        exp_e [4];
    exp_d = '{64'h0, 64'h0, 64'h0, D2};
    exp_e = '{1'b0, 1'b1, 1'b1, 1'b0};
    a_hs_q.delete(); a_rsp_q.delete();
    a_drive(1'b1, 1'b1, 12'h000, D2, 8'hFF);
    a_drive(1'b1, 1'b1, 12'h800, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    a_drive(1'b1, 1'b0, 12'h800, 64'h0, 8'h0);
    a_drive(1'b1, 1'b0, 12'h000, 64'h0, 8'h0);
    a_idle(6);
    n_checks++;
    if (a_rsp_q.size() != 4) begin
      n_errors++; $display("FAIL oor_count: got %0d want 4", a_rsp_q.size());
    end
    for (int i = 0; i < 4; i++) begin
      if (i < a_rsp_q.size()) begin
        n_checks++;
        if (a_rsp_q[i].rdata !== exp_d[i] || a_rsp_q[i].err !== exp_e[i]) begin
          n_errors++;
          $display("FAIL oor_rsp[%0d]: got %h err=%b want %h err=%b",
                   i, a_rsp_q[i].rdata, a_rsp_q[i].err, exp_d[i], exp_e[i]);
        end
      end
    end
  endtask

  task automatic test_stats;
    // A write presented during reset must be dropped.
    a_rst = 1'b1;
    a_drive(1'b1, 1'b1, 12'h010, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF);
    a_rst = 1'b0;
    n_checks++;
    if (a_rd_cnt !== 32'h0 || a_wr_cnt !== 32'h0) begin
      n_errors++;
      $display("FAIL stats_reset: got rd=%0d wr=%0d want 0 0", a_rd_cnt, a_wr_cnt);
    end
    a_hs_q.delete(); a_rsp_q.delete();
    a_drive(1'b1, 1'b0, 12'h010, 64'h0, 8'h0);
    a_drive(1'b1, 1'b1, 12'h030, 64'h3, 8'hFF);
    a_drive(1'b1, 1'b0, 12'h020, 64'h0, 8'h0);
    a_drive(1'b1, 1'b0, 12'h800, 64'h0, 8'h0);
    a_drive(1'b1, 1'b1, 12'h038, 64'h4, 8'hFF);
    a_drive(1'b1, 1'b0, 12'h000, 64'h0, 8'h0);
    a_drive(1'b1, 1'b1, 12'h900, 64'h5, 8'hFF);
    a_drive(1'b1, 1'b0, 12'h030, 64'h0, 8'h0);
    a_idle(6);
    n_checks++;
    if (a_rsp_q.size() != 8) begin
      n_errors++; $display("FAIL stats_rsp_count: got %0d want 8", a_rsp_q.size());
    end else if (a_rsp_q[0].rdata !== D1 || a_rsp_q[7].rdata !== 64'h3) begin
      n_errors++;
      $display("FAIL stats_persist: got %h %h want %h 0000000000000003",
               a_rsp_q[0].rdata, a_rsp_q[7].rdata, D1);
    end
    n_checks++;
    if (a_rd_cnt !== ExpRd || a_wr_cnt !== ExpWr) begin
      n_errors++;
      $display("FAIL stats_cnt: got rd=%0d wr=%0d want %0d %0d", a_rd_cnt, a_wr_cnt, ExpRd, ExpWr);
    end
  endtask

  task automatic test_stall;
    logic        exp_g [6];
    logic [63:0] exp_d [4];
    logic [11:0] rd_addr [4];
    int          idx;
    int          guard;
    exp_g   = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    exp_d   = '{64'd1, 64'd2, 64'd4, 64'd5};
    rd_addr = '{12'h000, 12'h008, 12'h018, 12'h020};
    b_rst = 1'b1; b_idle(1); b_rst = 1'b0;
    b_hs_q.delete(); b_rsp_q.delete();
    for (int k = 0; k < 6; k++) begin
      b_req = 1'b1; b_we = 1'b1; b_addr = 12'(k * 8); b_wdata = 64'(k + 1); b_strb = 8'hFF;
      #1;
      n_checks++;
      if (b_gnt !== exp_g[k]) begin
        n_errors++; $display("FAIL stall_gnt[%0d]: got %b want %b", k, b_gnt, exp_g[k]);
      end
      @(posedge clk); #1;
    end
    b_idle(7);
    n_checks++;
    if (b_hs_q.size() != 4 || b_rsp_q.size() != 4) begin
      n_errors++;
      $display("FAIL stall_count: got hs=%0d rsp=%0d want 4 4", b_hs_q.size(), b_rsp_q.size());
    end
    for (int i = 0; i < 4; i++) begin
      if (i < b_hs_q.size() && i < b_rsp_q.size()) begin
        n_checks++;
        if (b_rsp_q[i].cyc - b_hs_q[i] != 4) begin
          n_errors++;
          $display("FAIL stall_latency[%0d]: got %0d want 4", i, b_rsp_q[i].cyc - b_hs_q[i]);
        end
      end
    end
    // Read back the granted words holding each request until accepted.
    b_hs_q.delete(); b_rsp_q.delete();
    idx = 0; guard = 0;
    while (idx < 4 && guard < 20) begin
      b_req = 1'b1; b_we = 1'b0; b_addr = rd_addr[idx];
      #1;
      if (b_gnt) idx++;
      @(posedge clk); #1;
      guard++;
    end
    n_checks++;
    if (idx != 4) begin
      n_errors++; $display("FAIL stall_rd_timeout: got %0d grants want 4", idx);
    end
    b_idle(7);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (i >= b_rsp_q.size()) begin
        n_errors++; $display("FAIL stall_order[%0d]: got no response want %h", i, exp_d[i]);
      end else if (b_rsp_q[i].rdata !== exp_d[i]) begin
        n_errors++;
        $display("FAIL stall_order[%0d]: got %h want %h", i, b_rsp_q[i].rdata, exp_d[i]);
      end
    end
  endtask

  task automatic test_reset_midflight;
    logic        exp_g [4];
    logic [11:0] addrs [4];
    int          rst_cyc;
    int          late;
    exp_g = '{1'b1, 1'b1, 1'b0, 1'b1};
    addrs = '{12'h000, 12'h008, 12'h018, 12'h018};
    b_rst = 1'b1; b_idle(1); b_rst = 1'b0;
    b_hs_q.delete(); b_rsp_q.delete();
    for (int k = 0; k < 4; k++) begin
      b_req = 1'b1; b_we = 1'b0; b_addr = addrs[k];
      #1;
      n_checks++;
      if (b_gnt !== exp_g[k]) begin
        n_errors++; $display("FAIL mid_gnt[%0d]: got %b want %b", k, b_gnt, exp_g[k]);
      end
      @(posedge clk); #1;
    end
    b_req = 1'b0; b_rst = 1'b1; rst_cyc = cyc;
    @(posedge clk); #1;
    b_rst = 1'b0;
    b_idle(8);
    late = 0;
    foreach (b_rsp_q[i]) if (b_rsp_q[i].cyc > rst_cyc) late++;
    n_checks++;
    if (late != 0) begin
      n_errors++; $display("FAIL mid_no_rvalid: got %0d responses after reset want 0", late);
    end
    n_checks++;
    if (b_rd_cnt !== 32'h0 || b_wr_cnt !== 32'h0) begin
      n_errors++; $display("FAIL mid_cnt: got rd=%0d wr=%0d want 0 0", b_rd_cnt, b_wr_cnt);
    end
    for (int k = 0; k < 3; k++) begin
      b_req = 1'b1; b_we = 1'b0; b_addr = 12'h000;
      #1;
      n_checks++;
      if (b_gnt !== exp_g[k]) begin
        n_errors++; $display("FAIL mid_post_gnt[%0d]: got %b want %b", k, b_gnt, exp_g[k]);
      end
      @(posedge clk); #1;
    end
    b_idle(6);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "simulation time limit");
  end

  initial begin
    test_reset();
    test_write_read();
    test_strobes();
    test_out_of_range();
    test_stats();
    test_stall();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/tb_latency_mem.md
# tb_latency_mem

Parametrised testbench memory for the memory side of an AXI-to-memory bridge. It replaces a fixed one-cycle SRAM responder with configurable size, data width and read latency, periodic grant back-pressure, byte-strobe writes, and out-of-range error flagging. It sits in the testharness behind the external-slave AXI port, so software sees a memory whose latency and stall behaviour can be varied per build.

## Interface
- NumWords, 256: memory depth in words.
- DataWidth, 64: word width in bits; a multiple of 8.
- AddrWidth, 12: byte-address width of `addr_i`.
- ReadLatency, 1: cycles from grant to `rvalid_o`; legal range 1..8.
- GntStallPeriod, 0: deassert grant for one request cycle after this many handshakes; 0 = never stall.
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- req_i  in  1  request valid.
- gnt_o  out  1  request accepted this cycle.
- addr_i  in  AddrWidth  byte address.
- we_i  in  1  1 = write, 0 = read.
- wdata_i  in  DataWidth  write data.
- strb_i  in  DataWidth/8  byte enables for writes.
- rvalid_o  out  1  response valid, one per granted request.
- rdata_o  out  DataWidth  read data; '0 for writes and errors.
- err_o  out  1  response is for an out-of-range address; qualified by `rvalid_o`.
- rd_cnt_o  out  32  granted reads since reset (stats).
- wr_cnt_o  out  32  granted writes since reset (stats).

## Operation
- Word index = `addr_i[AddrWidth-1:$clog2(DataWidth/8)]`. The access is out of range when the index is ≥ NumWords.
- Handshake occurs when `req_i && gnt_o`. The block accepts one request per cycle and never stalls responses.
- `gnt_o = req_i && !stall`. The grant path is combinational from `req_i`.
- Stall rule:
  - Counter `gcnt` increments on every handshake.
  - When `gcnt == GntStallPeriod` (and GntStallPeriod > 0), the next cycle with `req_i` high gets `gnt_o = 0`, and `gcnt` clears to 0 in that cycle.
  - Cycles with `req_i` low do not consume the stall.
- Write handshake, in range: bytes with `strb_i[b]` set are updated at the clock edge; other bytes are unchanged.
- Write handshake, out of range: the write is dropped.
- Read handshake: data is sampled from the array in the grant cycle. A write granted at cycle t is visible to a read granted at t+1.
- Every handshake, read or write, enters a delay line of ReadLatency stages carrying {valid, rdata, err}.
  - Read: rdata is the memory word; for out-of-range reads it is '0.
  - Write: rdata is '0.
  - err = out of range.
- Responses return strictly in request order.
- Reset:
  - Clears `gcnt`, the delay line and the stats counters. In-flight responses are discarded with no `rvalid_o`.
  - Array contents are not cleared.
- Simultaneous events:
  - The stall cycle and reset in the same cycle: reset wins.
  - A handshake in the reset cycle is ignored, including its write.

## Timing
- Reset values: `gnt_o` follows `req_i` combinationally (grant may assert in the first cycle after reset); `rvalid_o = 0`, `rdata_o = 0`, `err_o = 0`, `rd_cnt_o = 0`, `wr_cnt_o = 0`.
- Latency: handshake at edge t produces `rvalid_o` high in cycle t+ReadLatency, for exactly one cycle per handshake.
- Throughput: one request per cycle, reduced only by stall cycles.
- Outputs `rvalid_o`, `rdata_o` and `err_o` are registered.

## Configuration
- Macro: `TB_LATENCY_MEM_STATS_EN`.
- Defined:
  - `rd_cnt_o` and `wr_cnt_o` count read and write handshakes respectively; out-of-range accesses are included.
  - Both wrap modulo 2^32.
- Undefined:
  - The counters are not instantiated; both ports are tied to '0.
  - All other behaviour is identical.

## Structure
- Package `tb_latency_mem_pkg` holds:
  - `MaxReadLatency = 8`.
  - The response struct typedef {valid, err, rdata}, parametrised via a `DataWidth` localparam default of 64.
  - `StatsWidth = 32`.
- Sub-module `tb_latency_mem_pipe`: a parametrised shift register of Depth response structs with synchronous active-high clear. It is instantiated once with Depth = ReadLatency.
- Elaboration-time assertions check:
  - ReadLatency within 1..8.
  - DataWidth % 8 == 0.
  - NumWords ≤ 2^(AddrWidth - $clog2(DataWidth/8)).

## Test plan
- **Write/read, ReadLatency=3.** Write 64'h1122_3344_5566_7788 to 0x010 with strb 8'hFF, then read 0x010. Expect `rvalid_o` exactly 3 cycles after each grant and read data 64'h1122_3344_5566_7788 with `err_o = 0`.
- **Byte strobes.** Write 64'h0 (strb 8'hFF), then write 64'hFFFF_FFFF_FFFF_FFFF with strb 8'h0F to 0x020, then read 0x020. Expect 64'h0000_0000_FFFF_FFFF.
- **Grant stall, GntStallPeriod=2.** Hold `req_i` high for 6 cycles. Expect `gnt_o` pattern 1,1,0,1,1,0 and exactly 4 responses, in order.
- **Out of range, NumWords=256, DataWidth=64.** Write to byte address 0x800, then read it. Expect both responses with `err_o = 1`, read data '0, and memory unchanged.
- **Reset mid-flight, ReadLatency=4.** Issue 3 back-to-back reads, then assert `rst_i` one cycle after the last grant. Expect no `rvalid_o` afterwards, and the counters read 0 after reset.
- **Stats enabled.** With `TB_LATENCY_MEM_STATS_EN` defined, perform 5 reads and 3 writes. Expect `rd_cnt_o = 5` and `wr_cnt_o = 3`; with the macro undefined, both are 0.
